// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage sitting directly after the program counter. It
// samples the PC, issues a read to instruction memory, captures the returned
// word into the instruction register and hands it to the decoder through a
// valid/ready handshake. A one-cycle pc_increment pulse is produced once per
// completed fetch and is the only thing that advances the PC.
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset, aborts any fetch
//   enable       in   run control, sampled in IDLE and on the HOLD accept edge
//   pc           in   current PC value (AW bits)
//   pc_increment out  registered one-cycle pulse to the PC
//   mem_addr     out  registered instruction memory address (AW bits)
//   mem_rd       out  registered read request
//   mem_rdata    in   read data, valid while mem_ready=1 (DW bits)
//   mem_ready    in   memory completes the read on this edge
//   ir           out  instruction register (DW bits)
//   ir_valid     out  ir holds an unconsumed instruction
//   ir_ready     in   decoder accepts ir
//   fetch_err    out  sticky memory-timeout flag
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] pc,
  output logic          pc_increment,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          fetch_err
);

  // Counter wide enough to hold values 0..TIMEOUT.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_REQ  = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          pc_inc_q, pc_inc_d;
  logic          fetch_err_q, fetch_err_d;

  // The timeout fires on the not-ready edge that brings the count to TIMEOUT.
  logic          timeout_s;
  assign timeout_s = (wait_cnt_q == CNT_LAST);

  // State and output registers; reset wins over everything, including a
  // mem_ready that coincides with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      pc_inc_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      pc_inc_q    <= pc_inc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ADDR;
        else        state_d = S_IDLE;
      end
      S_ADDR: state_d = S_REQ;
      S_REQ: begin
        if (mem_ready)      state_d = S_HOLD;
        else if (timeout_s) state_d = S_ERR;
        else                state_d = S_REQ;
      end
      S_HOLD: begin
        if (ir_ready) state_d = enable ? S_ADDR : S_IDLE;
        else          state_d = S_HOLD;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter. The ADDR
  // cycle exists so the PC, bumped by the pulse issued in the first HOLD
  // cycle, has settled before it is sampled.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    pc_inc_d    = 1'b0;
    fetch_err_d = fetch_err_q;
    case (state_q)
      S_IDLE: begin
        mem_rd_d = 1'b0;
      end
      S_ADDR: begin
        mem_addr_d = pc;
        mem_rd_d   = 1'b1;
        wait_cnt_d = '0;
      end
      S_REQ: begin
        if (mem_ready) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
          pc_inc_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          if (timeout_s) begin
            mem_rd_d    = 1'b0;
            fetch_err_d = 1'b1;
          end else begin
            mem_rd_d    = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (ir_ready) ir_valid_d = 1'b0;
        else          ir_valid_d = 1'b1;
      end
      S_ERR: begin
        mem_rd_d    = 1'b0;
        ir_valid_d  = 1'b0;
        fetch_err_d = 1'b1;
      end
      default: begin
        mem_rd_d   = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  assign pc_increment = pc_inc_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign ir           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level reference model predicts every
// output each cycle; directed scenarios pin the model with literal values and
// a randomized phase exercises handshakes, memory waits, timeouts and resets.
module tb_fetch_unit;
  localparam int TO = 15;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, pc_increment, mem_rd, mem_ready, ir_valid, ir_ready, fetch_err;
  logic [15:0] pc, mem_addr, mem_rdata, ir;
  int          mem_mode;
  logic        pc_load_en;
  logic [15:0] pc_load_val;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        chk_on  = 1'b0;

  fetch_unit #(.AW(16), .DW(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc),
    .pc_increment(pc_increment), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .fetch_err(fetch_err)
  );

  // Memory contents as a pure function of address.
  function automatic logic [15:0] mem_word(input int mode, input logic [15:0] a);
    case (mode)
      0:       return 16'hA5A5;
      1:       return 16'h1000 + a;
      default: return (a * 16'd3) ^ 16'h5A5A;
    endcase
  endfunction
  assign mem_rdata = mem_word(mem_mode, mem_addr);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Program counter: loadable, advanced only by the DUT's pulse.
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    rst_seen <= reset;
    if (pc_load_en)        pc <= pc_load_val;
    else if (pc_increment) pc <= pc + 16'd1;
  end

  // Reference model: tracks one fetch transaction at a time.
  //   launch  - the address will be taken from the PC on the next edge
  //   rd      - a read is outstanding, counting wait edges
  //   valid   - a captured word waits for the decoder
  //   parked  - nothing to do until enable
  logic [15:0] e_addr, e_ir;
  logic        e_rd, e_valid, e_inc, e_err, m_launch, m_parked;
  int          m_waits;
  always @(posedge clk) begin : model
    logic [15:0] a, r;
    logic        rd, v, inc, er, la, pk;
    int          w;
    a = e_addr; r = e_ir; rd = e_rd; v = e_valid; er = e_err;
    la = m_launch; pk = m_parked; w = m_waits; inc = 1'b0;
    if (reset) begin
      a = 16'd0; r = 16'd0; rd = 1'b0; v = 1'b0; er = 1'b0;
      la = 1'b0; pk = 1'b1; w = 0;
    end else if (er) begin
      rd = 1'b0; v = 1'b0;
    end else if (la) begin
      a = pc; rd = 1'b1; w = 0; la = 1'b0;
    end else if (rd) begin
      if (mem_ready) begin
        r = mem_word(mem_mode, a); v = 1'b1; rd = 1'b0; inc = 1'b1;
      end else begin
        w++;
        if (w == TO) begin
          rd = 1'b0; er = 1'b1;
        end
      end
    end else if (v) begin
      if (ir_ready) begin
        v = 1'b0;
        if (enable) la = 1'b1;
        else        pk = 1'b1;
      end
    end else if (pk && enable) begin
      la = 1'b1; pk = 1'b0;
    end
    e_addr <= a; e_ir <= r; e_rd <= rd; e_valid <= v; e_inc <= inc; e_err <= er;
    m_launch <= la; m_parked <= pk; m_waits <= w;
  end

  // Per-cycle compare plus whole-run properties: increment pulses counted,
  // each new read address is the previous one plus one.
  int          inc_cnt = 0;
  logic        prev_rd = 1'b0;
  logic        have_prev = 1'b0;
  logic [15:0] prev_addr = 16'd0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("cyc_mem_rd", 32'(mem_rd), 32'(e_rd));
      chk("cyc_ir", 32'(ir), 32'(e_ir));
      chk("cyc_ir_valid", 32'(ir_valid), 32'(e_valid));
      chk("cyc_pc_increment", 32'(pc_increment), 32'(e_inc));
      chk("cyc_fetch_err", 32'(fetch_err), 32'(e_err));
      if (rst_seen) begin
        inc_cnt   <= 0;
        have_prev <= 1'b0;
        prev_rd   <= 1'b0;
      end else begin
        if (pc_increment) inc_cnt <= inc_cnt + 1;
        if (mem_rd && !prev_rd) begin
          if (have_prev) chk("addr_seq", 32'(mem_addr), 32'(prev_addr + 16'd1));
          prev_addr <= mem_addr;
          have_prev <= 1'b1;
        end
        prev_rd <= mem_rd;
      end
    end
  end

  task automatic apply_reset(input logic [15:0] pcv, input int mode);
    reset = 1'b1; pc_load_en = 1'b1; pc_load_val = pcv; mem_mode = mode;
    @(negedge clk);
    reset = 1'b0; pc_load_en = 1'b0;
  endtask

  initial begin
    int outage;
    reset = 1'b1; enable = 1'b0; mem_ready = 1'b0; ir_ready = 1'b0;
    mem_mode = 0; pc_load_en = 1'b1; pc_load_val = 16'd0;
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);

    // Zero-wait first fetch.
    enable = 1'b1; mem_ready = 1'b1; ir_ready = 1'b1;
    reset = 1'b0; pc_load_en = 1'b0;
    @(negedge clk);
    chk("t1_e1_rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    chk("t1_e2_rd", 32'(mem_rd), 32'd1);
    chk("t1_e2_addr", 32'(mem_addr), 32'h0000);
    @(negedge clk);
    chk("t1_e3_ir", 32'(ir), 32'hA5A5);
    chk("t1_e3_valid", 32'(ir_valid), 32'd1);
    chk("t1_e3_inc", 32'(pc_increment), 32'd1);
    @(negedge clk);
    chk("t1_e4_inc", 32'(pc_increment), 32'd0);
    chk("t1_e4_pc", 32'(pc), 32'h0001);

    // Back-to-back stream.
    enable = 1'b1; mem_ready = 1'b1; ir_ready = 1'b1;
    apply_reset(16'h0000, 1);
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(negedge clk);
      chk("t2_ir", 32'(ir), 32'h1000 + 32'(k));
      chk("t2_valid", 32'(ir_valid), 32'd1);
    end
    #1 chk("t2_inc_count", 32'(inc_cnt), 32'd4);

    // Decoder stall for 5 cycles.
    enable = 1'b1; mem_ready = 1'b1; ir_ready = 1'b0;
    apply_reset(16'h0000, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_ir", 32'(ir), 32'h1000);
      chk("t3_stall_valid", 32'(ir_valid), 32'd1);
    end
    #1 chk("t3_inc_count", 32'(inc_cnt), 32'd1);
    ir_ready = 1'b1;
    @(negedge clk);
    chk("t3_accept_rd", 32'(mem_rd), 32'd0);
    ir_ready = 1'b0;
    @(negedge clk);
    chk("t3_next_rd", 32'(mem_rd), 32'd1);
    chk("t3_next_addr", 32'(mem_addr), 32'h0001);

    // Memory wait of 3 cycles, then a timeout.
    enable = 1'b1; mem_ready = 1'b0; ir_ready = 1'b0;
    apply_reset(16'h0010, 2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_wait_rd", 32'(mem_rd), 32'd1);
      chk("t4_wait_addr", 32'(mem_addr), 32'h0010);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t4_ir", 32'(ir), 32'h5A6A);
    chk("t4_err0", 32'(fetch_err), 32'd0);
    mem_ready = 1'b0; ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    @(negedge clk);
    chk("t4_req2_addr", 32'(mem_addr), 32'h0011);
    repeat (14) @(negedge clk);
    chk("t4_err_early", 32'(fetch_err), 32'd0);
    @(negedge clk);
    chk("t4_err", 32'(fetch_err), 32'd1);
    chk("t4_err_rd", 32'(mem_rd), 32'd0);
    #1 chk("t4_err_inc_count", 32'(inc_cnt), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enable = 1'($urandom); mem_ready = 1'($urandom); ir_ready = 1'($urandom);
      chk("t4_err_sticky", 32'(fetch_err), 32'd1);
    end

    // Drop enable during REQ.
    enable = 1'b1; mem_ready = 1'b0; ir_ready = 1'b0;
    apply_reset(16'h0100, 1);
    repeat (2) @(negedge clk);
    enable = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("t5_ir", 32'(ir), 32'h1100);
    mem_ready = 1'b0; ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_idle_rd", 32'(mem_rd), 32'd0);
    chk("t5_idle_valid", 32'(ir_valid), 32'd0);
    enable = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 6 && !mem_rd; i++) @(negedge clk);
    chk("t5_resume_rd", 32'(mem_rd), 32'd1);
    chk("t5_resume_addr", 32'(mem_addr), 32'h0101);

    // Reset coincident with mem_ready during REQ.
    enable = 1'b1; mem_ready = 1'b0; ir_ready = 1'b0;
    apply_reset(16'h0200, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("t6_rd", 32'(mem_rd), 32'd0);
    chk("t6_ir", 32'(ir), 32'd0);
    chk("t6_valid", 32'(ir_valid), 32'd0);
    chk("t6_inc", 32'(pc_increment), 32'd0);
    reset = 1'b0;

    // Randomized traffic with memory outages and occasional resets.
    mem_mode = 2;
    outage = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 299) == 0);
      pc_load_en  = reset;
      pc_load_val = 16'($urandom);
      enable      = ($urandom_range(0, 9) != 0);
      ir_ready    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) outage = 20;
      if (outage > 0) begin
        mem_ready = 1'b0;
        outage--;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
      end
    end
    reset = 1'b0; pc_load_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Samples the PC value, issues a read to instruction memory and captures the returned word into the instruction register (IR).
- Presents the IR to the decoder through a valid/ready handshake.
- Pulses the PC's increment input exactly once per completed fetch; this pulse is the only source of PC advance.

Parameters:
- AW, 16, address width; matches the PC output width.
- DW, 16, instruction word width.
- TIMEOUT, 15, number of consecutive not-ready cycles in REQ before a fetch error is declared; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run control; new fetches start only while high.
- pc  input  AW  current PC value, from PC q.
- pc_increment  output  1  registered one-cycle pulse, to PC increment.
- mem_addr  output  AW  instruction memory address, registered.
- mem_rd  output  1  read request, registered.
- mem_rdata  input  DW  read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the read on this edge.
- ir  output  DW  instruction register.
- ir_valid  output  1  ir holds an unconsumed instruction.
- ir_ready  input  1  decoder accepts ir.
- fetch_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset: synchronous, active-high; takes effect at the edge where reset=1, overrides everything and aborts any in-flight fetch.
  - Resulting values: state=IDLE, mem_addr=0, mem_rd=0, ir=0, ir_valid=0, pc_increment=0, fetch_err=0, wait counter=0.
- States: IDLE, ADDR, REQ, HOLD, ERR.
  - IDLE: if enable=1, go to ADDR; otherwise stay.
  - ADDR: one cycle. At the exit edge: mem_addr<=pc, mem_rd<=1, wait counter<=0, go to REQ.
  - REQ: mem_rd=1 and mem_addr are held stable.
    - Edge with mem_ready=1: ir<=mem_rdata, ir_valid<=1, mem_rd<=0, pc_increment<=1, go to HOLD.
    - Edge with mem_ready=0: wait counter+1. If the counter reaches TIMEOUT: mem_rd<=0, fetch_err<=1, go to ERR.
    - No increment pulse is issued on a timeout.
  - HOLD: ir and ir_valid are held stable until accepted. pc_increment returns to 0 after exactly one cycle.
    - Edge with ir_ready=1: ir_valid<=0, ir keeps its value; go to ADDR if enable=1, else IDLE.
  - ERR: absorbing; only reset exits. Outputs: mem_rd=0, ir_valid=0, fetch_err=1.
- PC timing:
  - pc_increment is high during the first HOLD cycle, so the PC updates at the next edge.
  - ADDR samples pc no earlier than one edge after that update, so mem_addr always carries the incremented value. Each fetched address is exactly the previous one + 1.
  - No address is fetched twice or skipped.
- Throughput: with mem_ready=1 and ir_ready=1 continuously, one instruction every 3 cycles (ADDR, REQ, HOLD).
- enable is sampled only in IDLE and on the HOLD accept edge.
  - Dropping enable mid-fetch lets the in-flight fetch complete and be handed to the decoder, then the block parks in IDLE.
- ir_ready asserted outside HOLD is ignored. mem_ready asserted outside REQ is ignored.
- PC wrap from 0xFFFF to 0x0000 is handled by the PC. The fetch unit treats the address as an opaque AW-bit value.
- Reset during REQ drops mem_rd at that same edge. A mem_ready arriving on the reset edge is discarded, and no increment pulse is issued.

Test Plan:
- Reset, enable=1, pc=0x0000, memory returns 0xA5A5 with zero wait -> mem_addr=0x0000 and mem_rd=1 on the 2nd edge after reset release; ir=0xA5A5, ir_valid=1 and pc_increment=1 for exactly one cycle on the 3rd edge.
- Back-to-back stream, ir_ready=1, memory mem[n]=0x1000+n, PC model incrementing -> ir sequence 0x1000, 0x1001, 0x1002, 0x1003 at 3-cycle spacing; exactly 4 increment pulses; no repeated mem_addr.
- Decoder stall, ir_ready=0 for 5 cycles after ir_valid -> ir/ir_valid stable for all 5 cycles; single increment pulse; next mem_rd only after the accept edge + 1 cycle.
- Memory wait of 3 cycles (mem_ready low 3 cycles, then high) -> mem_addr/mem_rd held for 4 REQ cycles; one capture; fetch_err=0. Then mem_ready held low with TIMEOUT=15 -> fetch_err=1 after 15 wait cycles, mem_rd=0, no increment pulse; state stays ERR until reset.
- Drop enable during REQ -> fetch completes, ir delivered, after accept block sits in IDLE with mem_rd=0; re-raise enable -> fetch resumes at pc+1.
- Assert reset during REQ coincident with mem_ready=1 -> next cycle all outputs at reset values, ir=0, pc_increment=0.
